// File: rtl/div_unit_if.sv
// Divider request/result bundle between the execute-stage stall logic and div_unit.
// The master drives the request, and the slave (the divider) returns status and results.
interface div_unit_if #(
  parameter int SIZE = 31
);
  logic            start;
  logic            signed_op;
  logic [SIZE:0]   srca;
  logic [SIZE:0]   srcb;
  logic            busy;
  logic            done;
  logic            divzero;
  logic [SIZE:0]   quotient;
  logic [SIZE:0]   remainder;

  modport master (
    output start, signed_op, srca, srcb,
    input  busy, done, divzero, quotient, remainder
  );

  modport slave (
    input  start, signed_op, srca, srcb,
    output busy, done, divzero, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: restoring shift-subtract DIV/DIVU, one quotient bit per clock; done SIZE+2 clocks after start (1 on divide-by-zero).
// Start is sampled only in IDLE and is ignored while busy; the pipeline stalls on busy, so there is no other backpressure.
module div_unit #(
  parameter int SIZE = 31
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  io
);

  localparam int W  = SIZE + 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state, state_nxt;
  logic [SIZE:0]   rem, rem_nxt;
  logic [SIZE:0]   dvd, dvd_nxt;
  logic [SIZE:0]   dvs, dvs_nxt;
  logic [SIZE:0]   q_r, q_nxt;
  logic [SIZE:0]   r_r, r_nxt;
  logic            neg_q, neg_q_nxt;
  logic            neg_r, neg_r_nxt;
  logic            done_r, done_nxt;
  logic            dz_r, dz_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [SIZE+1:0] trial_sh, trial_diff;
  logic            a_neg, b_neg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    a_neg      = io.signed_op & io.srca[SIZE];
    b_neg      = io.signed_op & io.srcb[SIZE];
    // Remainder is always below the divisor, so the shifted value fits SIZE+2 bits.
    trial_sh   = {rem, dvd[SIZE]};
    trial_diff = trial_sh - {1'b0, dvs};

    state_nxt  = state;
    rem_nxt    = rem;
    dvd_nxt    = dvd;
    dvs_nxt    = dvs;
    q_nxt      = q_r;
    r_nxt      = r_r;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    done_nxt   = 1'b0;
    dz_nxt     = dz_r;
    count_nxt  = count;

    case (state)
      IDLE: begin
        if (io.start) begin
          neg_q_nxt = a_neg ^ b_neg;
          neg_r_nxt = a_neg;
          dvd_nxt   = a_neg ? -io.srca : io.srca;
          dvs_nxt   = b_neg ? -io.srcb : io.srcb;
          rem_nxt   = '0;
          count_nxt = '0;
          if (io.srcb == '0) begin
            done_nxt = 1'b1;
            dz_nxt   = 1'b1;
            q_nxt    = '1;
            r_nxt    = io.srca;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        // dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
        if (!trial_diff[SIZE+1]) begin
          rem_nxt = trial_diff[SIZE:0];
          dvd_nxt = {dvd[SIZE-1:0], 1'b1};
        end else begin
          rem_nxt = trial_sh[SIZE:0];
          dvd_nxt = {dvd[SIZE-1:0], 1'b0};
        end
        count_nxt = count + 1'b1;
        if (count == CW'(SIZE)) state_nxt = FIX;
      end
      FIX: begin
        q_nxt     = neg_q ? -dvd : dvd;
        r_nxt     = neg_r ? -rem : rem;
        done_nxt  = 1'b1;
        dz_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      count  <= '0;
    end else begin
      rem    <= rem_nxt;
      dvd    <= dvd_nxt;
      dvs    <= dvs_nxt;
      q_r    <= q_nxt;
      r_r    <= r_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      done_r <= done_nxt;
      dz_r   <= dz_nxt;
      count  <= count_nxt;
    end
  end

  assign io.busy      = (state != IDLE);
  assign io.done      = done_r;
  assign io.divzero   = dz_r;
  assign io.quotient  = q_r;
  assign io.remainder = r_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of DIV/DIVU vectors plus issue-overlap and reset-abort sequences.
module tb_div_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  div_unit_if #(.SIZE(31)) io ();

  div_unit #(.SIZE(31)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Holds start for exactly one edge (edge N); returns #1 after that edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    io.start     = 1'b1;
    io.signed_op = s;
    io.srca      = a;
    io.srcb      = b;
    @(posedge clk);
    #1;
    io.start = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    if (io.done) lat = 0;
    else begin
      for (int i = 1; i <= 100; i++) begin
        @(posedge clk);
        #1;
        if (io.done) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0, 33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 33};
    vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,         32'h80000000, 1'b0, 33};
    vecs[5]  = '{1'b0, 32'h00001234,   32'd0,        32'hFFFFFFFF,  32'h00001234, 1'b1, 0};
    vecs[6]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 1'b0, 33};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        1'b0, 33};
    vecs[8]  = '{1'b0, 32'd5,          32'd10,       32'd0,         32'd5,        1'b0, 33};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'd1,         32'd1,        1'b0, 33};
    vecs[10] = '{1'b1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF,  32'hFFFFFFFB, 1'b1, 0};
    vecs[11] = '{1'b0, 32'hDEADBEEF,   32'h10,       32'h0DEADBEE,  32'hF,        1'b0, 33};

    io.start = 1'b0; io.signed_op = 1'b0; io.srca = '0; io.srcb = '0;
    #1;
    check("rst.busy", {31'd0, io.busy}, 32'd0);
    check("rst.done", {31'd0, io.done}, 32'd0);
    check("rst.divzero", {31'd0, io.divzero}, 32'd0);
    check("rst.q", io.quotient, 32'd0);
    check("rst.r", io.remainder, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d.busy_run", i), {31'd0, io.busy}, {31'd0, (vecs[i].lat != 0)});
      wait_done(lat);
      check_int($sformatf("v%0d.lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d.q", i), io.quotient, vecs[i].q);
      check($sformatf("v%0d.r", i), io.remainder, vecs[i].r);
      check($sformatf("v%0d.dz", i), {31'd0, io.divzero}, {31'd0, vecs[i].dz});
      check($sformatf("v%0d.busy_done", i), {31'd0, io.busy}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.done_pulse", i), {31'd0, io.done}, 32'd0);
      check($sformatf("v%0d.dz_hold", i), {31'd0, io.divzero}, {31'd0, vecs[i].dz});
    end

    // Mid-operation start is ignored; start on the done cycle is accepted.
    issue(1'b0, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    io.start = 1'b1; io.srca = 32'd9; io.srcb = 32'd3;
    @(posedge clk);
    #1 io.start = 1'b0;
    wait_done(lat);
    check_int("ovl.lat1", lat, 28);
    check("ovl.q1", io.quotient, 32'd14);
    check("ovl.r1", io.remainder, 32'd2);
    issue(1'b0, 32'd9, 32'd3);
    check("ovl.done_drop", {31'd0, io.done}, 32'd0);
    check("ovl.busy2", {31'd0, io.busy}, 32'd1);
    wait_done(lat);
    check_int("ovl.lat2", lat, 33);
    check("ovl.q2", io.quotient, 32'd3);
    check("ovl.r2", io.remainder, 32'd0);

    // Asynchronous reset mid-operation aborts without a done.
    @(posedge clk);
    #1;
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("arst.busy", {31'd0, io.busy}, 32'd0);
    check("arst.q", io.quotient, 32'd0);
    check("arst.r", io.remainder, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (io.done) done_seen++;
    end
    check_int("arst.no_done", done_seen, 0);
    issue(1'b0, 32'd9, 32'd3);
    wait_done(lat);
    check_int("arst.lat", lat, 33);
    check("arst.q_new", io.quotient, 32'd3);
    check("arst.r_new", io.remainder, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
